// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: types and constants shared by the program loader files.
//   prog_state_t        - loader FSM states (WAIT, LOAD, CLEAR, BOOT, RUN)
//   addr_t / data_t     - 6-bit program address, 8-bit instruction word
//   PROG_DEPTH          - number of program words (full addr_t space)
//   BOOT_CYCLES_DEFAULT - cycles the CPU stays in reset after a load
package prog_loader_pkg;

  localparam int ADDR_W              = 6;
  localparam int DATA_W              = 8;
  localparam int PROG_DEPTH          = 64;
  localparam int BOOT_CYCLES_DEFAULT = 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_BOOT  = 3'd3,
    ST_RUN   = 3'd4
  } prog_state_t;

endpackage

// File: rtl/prog_loader_ram.sv
// prog_ram: program storage, DEPTH x 8 bits.
//   clock             - write clock
//   we_i/waddr_i/wdata_i - synchronous write port
//   raddr_i/rdata_o   - asynchronous read port
// Contents are deliberately not reset so a reset keeps written words.
module prog_ram
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = PROG_DEPTH
) (
  input  logic  clock,
  input  logic  we_i,
  input  addr_t waddr_i,
  input  data_t wdata_i,
  input  addr_t raddr_i,
  output data_t rdata_o
);

  data_t mem [DEPTH];

  // Synchronous write port
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a program image from a host into program RAM, zero-fills
// the unused tail, holds the CPU in reset for BOOT_CYCLES, then releases it.
//   clock, reset      - clock and synchronous active-low reset
//   cpu_addr/cpu_data - CPU instruction fetch (data is 00 unless running)
//   cpu_reset         - active-low CPU reset, high only in RUN
//   load_start        - pulse requesting a new load (honoured in WAIT/RUN)
//   load_valid/data/last, load_ready - host word handshake
//   busy              - high in every state except RUN
//   loaded_words      - words accepted by the most recent load
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int BOOT_CYCLES = BOOT_CYCLES_DEFAULT,
  parameter int DEPTH       = PROG_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  addr_t      cpu_addr,
  output data_t      cpu_data,
  output logic       cpu_reset,
  input  logic       load_start,
  input  logic       load_valid,
  input  data_t      load_data,
  input  logic       load_last,
  output logic       load_ready,
  output logic       busy,
  output logic [6:0] loaded_words
);

  localparam addr_t      LAST_ADDR = addr_t'(DEPTH - 1);
  localparam logic [7:0] BOOT_LOAD = 8'(BOOT_CYCLES - 1);

  prog_state_t state_q, state_d;
  addr_t       ptr_q, ptr_d;
  logic [7:0]  boot_cnt_q, boot_cnt_d;
  logic [6:0]  words_q, words_d;
  logic        ram_we;
  data_t       ram_wdata;
  data_t       ram_rdata;

  // Next-state, pointer, counter and RAM write control
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    boot_cnt_d = boot_cnt_q;
    words_d    = words_q;
    ram_we     = 1'b0;
    ram_wdata  = 8'h00;
    case (state_q)
      ST_WAIT, ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = 6'd0;
          words_d = 7'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        // load_ready is high for the whole state, so valid alone accepts
        if (load_valid) begin
          ram_we    = 1'b1;
          ram_wdata = load_data;
          ptr_d     = ptr_q + 6'd1;
          words_d   = words_q + 7'd1;
          if (ptr_q == LAST_ADDR) begin
            // Memory is full: nothing left to clear
            state_d    = ST_BOOT;
            boot_cnt_d = BOOT_LOAD;
          end else if (load_last) begin
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_CLEAR: begin
        ram_we = 1'b1;
        ptr_d  = ptr_q + 6'd1;
        if (ptr_q == LAST_ADDR) begin
          state_d    = ST_BOOT;
          boot_cnt_d = BOOT_LOAD;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_BOOT: begin
        // Loaded with BOOT_CYCLES-1 so the state lasts exactly BOOT_CYCLES
        if (boot_cnt_q == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_WAIT;
      ptr_q      <= 6'd0;
      boot_cnt_q <= 8'd0;
      words_q    <= 7'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      boot_cnt_q <= boot_cnt_d;
      words_q    <= words_d;
    end
  end

  // Writes are suppressed on a reset edge so reset never corrupts memory
  prog_ram #(.DEPTH(DEPTH)) u_ram (
    .clock   (clock),
    .we_i    (ram_we & reset),
    .waddr_i (ptr_q),
    .wdata_i (ram_wdata),
    .raddr_i (cpu_addr),
    .rdata_o (ram_rdata)
  );

  assign cpu_reset    = (state_q == ST_RUN);
  assign busy         = (state_q != ST_RUN);
  assign load_ready   = (state_q == ST_LOAD);
  assign cpu_data     = (state_q == ST_RUN) ? ram_rdata : 8'h00;
  assign loaded_words = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed + randomized bench for prog_loader. A reference
// image of program memory is kept as a plain array and the expected load /
// clear / boot timing is computed arithmetically from the word count.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  addr_t      cpu_addr = 6'd0;
  data_t      cpu_data;
  logic       cpu_reset;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  data_t      load_data = 8'h00;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic       busy;
  logic [6:0] loaded_words;

  int    tests = 0;
  int    fails = 0;
  data_t model [64];

  prog_loader dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_data     (cpu_data),
    .cpu_reset    (cpu_reset),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .busy         (busy),
    .loaded_words (loaded_words)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Read every address in RUN and compare with the model image
  task automatic readback(input int n);
    chk("run_cpu_reset", cpu_reset, 1);
    chk("run_busy", busy, 0);
    chk("run_ready", load_ready, 0);
    chk("run_words", loaded_words, n);
    for (int a = 0; a < 64; a++) begin
      cpu_addr = addr_t'(a);
      #1;
      chk($sformatf("mem[%0d]", a), cpu_data, model[a]);
    end
  endtask

  // One complete load of n words; fixed_data uses the 31/42/F0 pattern
  task automatic do_load(input int n, input bit use_last, input bit toggle, input bit fixed_data);
    int    i;
    int    guard;
    int    k;
    bit    v;
    data_t d;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("start_ready", load_ready, 1);
    chk("start_cpu_reset", cpu_reset, 0);
    chk("start_cpu_data", cpu_data, 8'h00);
    chk("start_words", loaded_words, 0);
    i = 0;
    guard = 0;
    while (i < n && guard < 1000) begin
      v = toggle ? (guard % 2 == 0) : ($urandom % 4 != 0);
      if (fixed_data) begin
        v = 1'b1;
        d = (i == 0) ? 8'h31 : (i == 1) ? 8'h42 : 8'hF0;
      end else begin
        d = data_t'($urandom);
      end
      load_valid = v;
      load_data  = d;
      // Unqualified load_last and stray load_start must both be ignored
      load_last  = v ? (use_last && i == n - 1) : 1'($urandom % 2);
      load_start = 1'($urandom % 2);
      tick();
      if (v) begin
        model[i] = d;
        i++;
        chk("words_count", loaded_words, i);
      end
      guard++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("accepted", i, n);
    chk("post_load_ready", load_ready, 0);
    chk("post_load_busy", busy, 1);
    for (int a = n; a < 64; a++) model[a] = 8'h00;
    k = 0;
    while (!cpu_reset && k < 200) begin
      load_start = 1'($urandom % 2);
      tick();
      k++;
    end
    load_start = 1'b0;
    chk("clear_boot_cycles", k, (64 - n) + BOOT_CYCLES_DEFAULT);
    readback(n);
  endtask

  initial begin
    for (int a = 0; a < 64; a++) model[a] = 8'h00;
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_cpu_reset", cpu_reset, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_cpu_data", cpu_data, 8'h00);
    chk("rst_words", loaded_words, 0);
    reset = 1'b1;

    // Idle in WAIT for 10 cycles
    for (int c = 0; c < 10; c++) begin
      load_valid = 1'($urandom % 2);
      tick();
      chk("wait_flags", {cpu_reset, busy, load_ready}, 3'b010);
    end
    load_valid = 1'b0;

    // Three words with load_last on the third
    do_load(3, 1'b1, 1'b0, 1'b1);
    // Full 64-word image, valid toggling, load_last never set (from RUN)
    do_load(64, 1'b0, 1'b1, 1'b0);
    // Random-length loads with random valid gaps
    for (int r = 0; r < 2; r++) begin
      do_load($urandom_range(1, 63), 1'b1, 1'b0, 1'b0);
    end

    // Reset partway through a 10-word load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int w = 0; w < 5; w++) begin
      load_valid = 1'b1;
      load_data  = data_t'($urandom);
      model[w]   = load_data;
      tick();
    end
    load_valid = 1'b0;
    chk("abort_words", loaded_words, 5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_busy", busy, 1);
    chk("abort_ready", load_ready, 0);
    chk("abort_cpu_reset", cpu_reset, 0);
    chk("abort_words_rst", loaded_words, 0);
    tick();
    chk("abort_wait", {cpu_reset, busy, load_ready}, 3'b010);
    // Restart must begin at address 0
    do_load(4, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
